// File: rtl/m_stage_merge.sv
// Clocked two-into-one merge of the a/b branch streams over 4-phase active-low
// Send/Ack handshakes, with a 1-entry buffer per branch and round-robin output arbitration.
`timescale 1ns/1ps

module m_stage_merge_chan #(
    parameter int PACK_W = 39
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send_s,
    input  logic [PACK_W-1:0] pkt_in,
    input  logic              clr,
    output logic              ack,
    output logic              vld,
    output logic [PACK_W-1:0] data
);
    typedef enum logic {I_IDLE, I_HOLD} i_state_t;

    i_state_t          state_q, state_d;
    logic              ack_d, vld_d;
    logic [PACK_W-1:0] data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= I_IDLE;
            ack     <= 1'b1;
            vld     <= 1'b0;
            data    <= '0;
        end else begin
            state_q <= state_d;
            ack     <= ack_d;
            vld     <= vld_d;
            data    <= data_d;
        end
    end

    // clr only arrives while vld is set and capture needs vld clear, so they never collide
    always_comb begin
        state_d = state_q;
        ack_d   = ack;
        vld_d   = vld & ~clr;
        data_d  = data;
        case (state_q)
            I_IDLE: if (!send_s && !vld) begin
                data_d  = pkt_in;
                vld_d   = 1'b1;
                ack_d   = 1'b0;
                state_d = I_HOLD;
            end
            I_HOLD: if (send_s) begin
                ack_d   = 1'b1;
                state_d = I_IDLE;
            end
            default: state_d = I_IDLE;
        endcase
    end
endmodule

module m_stage_merge #(
    parameter int PACK_W      = 39,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              MR,
    input  logic              Send_in_a,
    output logic              Ack_out_a,
    input  logic [PACK_W-1:0] PACKET_IN_a,
    input  logic              Send_in_b,
    output logic              Ack_out_b,
    input  logic [PACK_W-1:0] PACKET_IN_b,
    output logic              Send_out,
    input  logic              Ack_in,
    output logic [PACK_W-1:0] PACKET_OUT
);
    localparam int NUM_CH = 2;

    typedef enum logic [1:0] {O_IDLE, O_SETUP, O_REQ, O_REL} o_state_t;

    // index 0 = channel a, 1 = channel b, 2 = downstream ack
    logic [2:0]                    raw;
    logic [2:0][SYNC_STAGES-1:0]   sync_q;
    logic [NUM_CH-1:0]             s_send;
    logic                          sk;

    logic [NUM_CH-1:0][PACK_W-1:0] pkt_in;
    logic [NUM_CH-1:0][PACK_W-1:0] buf_data;
    logic [NUM_CH-1:0]             vld, ack, clr;

    o_state_t          o_state_q, o_state_d;
    logic              send_d;
    logic [PACK_W-1:0] pkt_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;

    assign raw    = {Ack_in, Send_in_b, Send_in_a};
    assign pkt_in = {PACKET_IN_b, PACKET_IN_a};

    // idle level of every handshake line is 1, so the synchronizers reset high
    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            sync_q <= '1;
        end else begin
            for (int i = 0; i < 3; i++)
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        end
    end

    assign s_send = {sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};
    assign sk     = sync_q[2][SYNC_STAGES-1];

    generate
        for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
            m_stage_merge_chan #(.PACK_W(PACK_W)) u_chan (
                .clk    (CLK),
                .rst    (MR),
                .send_s (s_send[ch]),
                .pkt_in (pkt_in[ch]),
                .clr    (clr[ch]),
                .ack    (ack[ch]),
                .vld    (vld[ch]),
                .data   (buf_data[ch])
            );
        end
    endgenerate

    assign Ack_out_a = ack[0];
    assign Ack_out_b = ack[1];

    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            o_state_q  <= O_IDLE;
            Send_out   <= 1'b1;
            PACKET_OUT <= '0;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;   // last grant = b, so a wins the first tie
        end else begin
            o_state_q  <= o_state_d;
            Send_out   <= send_d;
            PACKET_OUT <= pkt_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
        end
    end

    always_comb begin
        o_state_d = o_state_q;
        send_d    = Send_out;
        pkt_d     = PACKET_OUT;
        grant_d   = grant_q;
        last_d    = last_q;
        clr       = '0;
        case (o_state_q)
            O_IDLE: if (|vld) begin
                grant_d   = (&vld) ? ~last_q : vld[1];
                last_d    = grant_d;
                pkt_d     = buf_data[grant_d];
                o_state_d = O_SETUP;
            end
            O_SETUP: begin
                send_d    = 1'b0;
                o_state_d = O_REQ;
            end
            // the buffer is held until the downstream ack, freeing it for the next capture
            O_REQ: if (!sk) begin
                send_d    = 1'b1;
                clr       = 2'b01 << grant_q;
                o_state_d = O_REL;
            end
            O_REL: if (sk) o_state_d = O_IDLE;
            default: o_state_d = O_IDLE;
        endcase
    end
endmodule

// File: tb/tb_m_stage_merge.sv
// Directed bench for m_stage_merge: upstream handshake tasks, a 2-cycle downstream
// responder, and an expected-packet queue compared whenever Send_out falls.
`timescale 1ns/1ps

module tb_m_stage_merge;
    localparam int PACK_W = 39;

    logic              CLK = 1'b0;
    logic              MR = 1'b1;
    logic              Send_in_a = 1'b1, Send_in_b = 1'b1, Ack_in = 1'b1;
    logic [PACK_W-1:0] PACKET_IN_a = '0, PACKET_IN_b = '0;
    logic              Ack_out_a, Ack_out_b, Send_out;
    logic [PACK_W-1:0] PACKET_OUT;

    int                checks = 0, errors = 0;
    logic [PACK_W-1:0] sb[$];
    bit                hold_ack = 1'b0;
    int                rp = 0, rc = 0, n_out = 0;

    always #0.5 CLK = ~CLK;

    m_stage_merge #(.PACK_W(PACK_W), .SYNC_STAGES(2)) dut (
        .CLK         (CLK),
        .MR          (MR),
        .Send_in_a   (Send_in_a),
        .Ack_out_a   (Ack_out_a),
        .PACKET_IN_a (PACKET_IN_a),
        .Send_in_b   (Send_in_b),
        .Ack_out_b   (Ack_out_b),
        .PACKET_IN_b (PACKET_IN_b),
        .Send_out    (Send_out),
        .Ack_in      (Ack_in),
        .PACKET_OUT  (PACKET_OUT)
    );

    task automatic chk(input string tag, input logic [PACK_W-1:0] obs, input logic [PACK_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // downstream: ack 2 cycles after Send_out falls, release 2 cycles after it rises
    initial begin
        forever begin
            @(negedge CLK);
            if (MR) begin
                rp = 0; rc = 0; Ack_in = 1'b1;
            end else begin
                case (rp)
                    0: if (Send_out === 1'b0) begin
                        checks++;
                        assert (sb.size() != 0) else begin
                            errors++;
                            $error("FAIL unexpected_pkt observed=%0h expected=none", PACKET_OUT);
                        end
                        if (sb.size() != 0) chk("pkt_order", PACKET_OUT, sb.pop_front());
                        n_out++; rp = 1; rc = 0;
                    end
                    1: if (!hold_ack) begin
                        rc++;
                        if (rc >= 2) begin Ack_in = 1'b0; rp = 2; end
                    end
                    2: if (Send_out === 1'b1) begin rp = 3; rc = 0; end
                    3: begin
                        rc++;
                        if (rc >= 2) begin Ack_in = 1'b1; rp = 0; end
                    end
                    default: rp = 0;
                endcase
            end
        end
    end

    task automatic wait_ack(input int ch, input logic val, input string tag);
        int n = 0;
        while (((ch == 0) ? Ack_out_a : Ack_out_b) !== val && n < 400) begin
            @(negedge CLK); n++;
        end
        chk(tag, (ch == 0) ? Ack_out_a : Ack_out_b, val);
    endtask

    task automatic send_pkt(input int ch, input logic [PACK_W-1:0] d, input int gap);
        @(negedge CLK);
        if (ch == 0) begin PACKET_IN_a = d; Send_in_a = 1'b0; end
        else         begin PACKET_IN_b = d; Send_in_b = 1'b0; end
        wait_ack(ch, 1'b0, $sformatf("ack_fall_%0d", ch));
        repeat (gap) @(negedge CLK);
        if (ch == 0) Send_in_a = 1'b1; else Send_in_b = 1'b1;
        wait_ack(ch, 1'b1, $sformatf("ack_rise_%0d", ch));
        repeat (gap) @(negedge CLK);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (!(sb.size() == 0 && rp == 0 && Send_out === 1'b1) && n < 600) begin
            @(negedge CLK); n++;
        end
        chk(tag, PACK_W'(sb.size()), '0);
        repeat (8) @(negedge CLK);
    endtask

    initial begin
        int n;
        int base;

        // 1: reset held with a pending request, then normal capture
        Send_in_a = 1'b0; PACKET_IN_a = 39'h5A5; sb.push_back(39'h5A5);
        repeat (12) begin
            @(negedge CLK);
            chk("rst_ack_a", Ack_out_a, 1'b1);
            chk("rst_send", Send_out, 1'b1);
            chk("rst_pkt", PACKET_OUT, '0);
        end
        MR = 1'b0;
        wait_ack(0, 1'b0, "post_rst_capture");
        Send_in_a = 1'b1;
        wait_ack(0, 1'b1, "post_rst_release");
        drain("t1_drain");

        // 2: single packet with exact latencies
        @(negedge CLK);
        PACKET_IN_a = 39'h0_0008_0001; Send_in_a = 1'b0; sb.push_back(39'h0_0008_0001);
        @(negedge CLK); chk("lat_e1_ack", Ack_out_a, 1'b1);
        @(negedge CLK); chk("lat_e2_ack", Ack_out_a, 1'b1);
        @(negedge CLK); chk("lat_e3_ack", Ack_out_a, 1'b0);
        @(negedge CLK); chk("lat_e4_send", Send_out, 1'b1);
        chk("lat_e4_pkt", PACKET_OUT, 39'h0_0008_0001);
        @(negedge CLK); chk("lat_e5_send", Send_out, 1'b0);
        Send_in_a = 1'b1;
        wait_ack(0, 1'b1, "t2_release");
        drain("t2_drain");
        chk("idle_ack_a", Ack_out_a, 1'b1);
        chk("idle_ack_b", Ack_out_b, 1'b1);
        chk("idle_send", Send_out, 1'b1);
        chk("hold_pkt", PACKET_OUT, 39'h0_0008_0001);

        // 3: ties from reset go to a; after a lone a grant, the next tie goes to b
        @(negedge CLK); MR = 1'b1;
        @(negedge CLK); MR = 1'b0;
        sb.push_back(39'h11); sb.push_back(39'h22);
        fork
            send_pkt(0, 39'h11, 0);
            send_pkt(1, 39'h22, 0);
        join
        drain("t3_drain_ab");
        sb.push_back(39'h33);
        send_pkt(0, 39'h33, 0);
        drain("t3_drain_lone");
        sb.push_back(39'h44); sb.push_back(39'h55);
        fork
            send_pkt(0, 39'h55, 0);
            send_pkt(1, 39'h44, 0);
        join
        drain("t3_drain_ba");

        // 4: downstream stalled; buffer b stays full so the next request is not acked
        hold_ack = 1'b1;
        sb.push_back(39'h4_0000_0001); sb.push_back(39'h4_0000_0002); sb.push_back(39'h4_0000_0003);
        send_pkt(1, 39'h4_0000_0001, 0);
        @(negedge CLK); PACKET_IN_b = 39'h4_0000_0002; Send_in_b = 1'b0;
        repeat (20) @(negedge CLK);
        chk("bp_ack_held", Ack_out_b, 1'b1);
        chk("bp_send_low", Send_out, 1'b0);
        chk("bp_pkt", PACKET_OUT, 39'h4_0000_0001);
        hold_ack = 1'b0;
        wait_ack(1, 1'b0, "bp_capture");
        Send_in_b = 1'b1;
        wait_ack(1, 1'b1, "bp_release");
        send_pkt(1, 39'h4_0000_0003, 0);
        drain("t4_drain");

        // 5: 7 alternating packets, 8 cycles per phase
        base = n_out;
        for (int i = 0; i < 7; i++) begin
            sb.push_back(39'h5_0000_0000 | 39'(i));
            send_pkt(i % 2, 39'h5_0000_0000 | 39'(i), 8);
        end
        drain("t5_drain");
        chk("stream_count", PACK_W'(n_out - base), 39'd7);

        // 6: reset while in O_REQ with both buffers full
        @(negedge CLK); MR = 1'b1;
        @(negedge CLK); MR = 1'b0;
        hold_ack = 1'b1;
        sb.push_back(39'h61);
        @(negedge CLK);
        PACKET_IN_a = 39'h61; PACKET_IN_b = 39'h62; Send_in_a = 1'b0; Send_in_b = 1'b0;
        wait_ack(0, 1'b0, "t6_cap_a");
        wait_ack(1, 1'b0, "t6_cap_b");
        n = 0;
        while (Send_out !== 1'b0 && n < 100) begin @(negedge CLK); n++; end
        chk("t6_req", Send_out, 1'b0);
        #0.1 MR = 1'b1;
        #0.1;
        chk("mr_ack_a", Ack_out_a, 1'b1);
        chk("mr_ack_b", Ack_out_b, 1'b1);
        chk("mr_send", Send_out, 1'b1);
        chk("mr_pkt", PACKET_OUT, '0);
        Send_in_a = 1'b1; Send_in_b = 1'b1; hold_ack = 1'b0;
        repeat (3) @(negedge CLK);
        MR = 1'b0;
        repeat (30) begin
            @(negedge CLK);
            chk("no_stale_send", Send_out, 1'b1);
        end
        chk("no_stale_pkt", PACKET_OUT, '0);
        chk("no_stale_ack_a", Ack_out_a, 1'b1);
        chk("sb_empty", PACK_W'(sb.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
